// File: rtl/damage_router_if.sv
// Connection bundle for damage_router: both damage handshakes, spawn/restart controls
// and the published game state.
interface damage_router_if #(
  parameter int NUM_SLOTS = 16,
  parameter int DMG_W     = 9,
  parameter int HP_W      = 10
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int SEL_W  = SLOT_W + 1;

  logic                      unit_dmg_valid;
  logic                      unit_dmg_ready;
  logic [SEL_W-1:0]          unit_dmg_sel;
  logic [DMG_W-1:0]          unit_dmg_amt;
  logic                      enemy_dmg_valid;
  logic                      enemy_dmg_ready;
  logic [SEL_W-1:0]          enemy_dmg_sel;
  logic [DMG_W-1:0]          enemy_dmg_amt;
  logic                      spawn_valid;
  logic                      spawn_side;
  logic [SLOT_W-1:0]         spawn_slot;
  logic [HP_W-1:0]           spawn_hp;
  logic                      restart;
  logic [NUM_SLOTS*HP_W-1:0] unit_hp;
  logic [NUM_SLOTS*HP_W-1:0] enemy_hp;
  logic [NUM_SLOTS-1:0]      unit_alive;
  logic [NUM_SLOTS-1:0]      enemy_alive;
  logic [HP_W-1:0]           friendly_tower_hp;
  logic [HP_W-1:0]           enemy_tower_hp;
  logic                      game_over;
  logic                      friendly_won;
  logic [7:0]                drop_count;

  modport master (
    output unit_dmg_valid, unit_dmg_sel, unit_dmg_amt,
    output enemy_dmg_valid, enemy_dmg_sel, enemy_dmg_amt,
    output spawn_valid, spawn_side, spawn_slot, spawn_hp, restart,
    input  unit_dmg_ready, enemy_dmg_ready,
    input  unit_hp, enemy_hp, unit_alive, enemy_alive,
    input  friendly_tower_hp, enemy_tower_hp, game_over, friendly_won, drop_count
  );

  modport slave (
    input  unit_dmg_valid, unit_dmg_sel, unit_dmg_amt,
    input  enemy_dmg_valid, enemy_dmg_sel, enemy_dmg_amt,
    input  spawn_valid, spawn_side, spawn_slot, spawn_hp, restart,
    output unit_dmg_ready, enemy_dmg_ready,
    output unit_hp, enemy_hp, unit_alive, enemy_alive,
    output friendly_tower_hp, enemy_tower_hp, game_over, friendly_won, drop_count
  );
endinterface

// File: rtl/damage_router.sv
// Per-side damage event queues feeding saturating HP updates for unit slots and towers,
// with a RUN/OVER game state machine. Side index 0 is friendly, 1 is enemy.
module damage_router #(
  parameter int NUM_SLOTS  = 16,
  parameter int DMG_W      = 9,
  parameter int HP_W       = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int TOWER_HP   = 500
) (
  input logic            clk,
  input logic            rst_n,
  damage_router_if.slave bus
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int SEL_W  = SLOT_W + 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int MW     = (DMG_W > HP_W) ? DMG_W : HP_W;
  localparam logic [HP_W-1:0]  TOWER_INIT = HP_W'(TOWER_HP);
  localparam logic [SEL_W-1:0] SEL_TOWER  = SEL_W'(NUM_SLOTS);
  localparam logic [AW:0]      PTR_ONE    = (AW+1)'(1);

  typedef enum logic {ST_RUN, ST_OVER} state_t;
  state_t r_state, w_state_next;

  logic [AW:0]          r_wr_ptr   [2];
  logic [AW:0]          r_rd_ptr   [2];
  logic [SEL_W-1:0]     r_fifo_sel [2][FIFO_DEPTH];
  logic [DMG_W-1:0]     r_fifo_amt [2][FIFO_DEPTH];
  logic [HP_W-1:0]      r_hp       [2][NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_alive    [2];
  logic [HP_W-1:0]      r_tower    [2];
  logic                 r_won;
  logic [7:0]           r_drop_count;

  logic             w_valid      [2];
  logic [SEL_W-1:0] w_in_sel     [2];
  logic [DMG_W-1:0] w_in_amt     [2];
  logic             w_full       [2];
  logic             w_empty      [2];
  logic             w_push       [2];
  logic [SEL_W-1:0] w_head_sel   [2];
  logic [DMG_W-1:0] w_head_amt   [2];
  logic [SLOT_W-1:0] w_slot      [2];
  logic             w_tower_hit  [2];
  logic             w_spawn      [2];
  logic             w_apply      [2];
  logic             w_drop       [2];
  logic [HP_W-1:0]  w_new_hp     [2];
  logic [HP_W-1:0]  w_tower_next [2];
  logic [1:0]       w_drop_inc;
  logic [8:0]       w_drop_sum;
  logic             w_run;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                              input logic [DMG_W-1:0] amt);
    logic [MW-1:0] hp_x;
    logic [MW-1:0] amt_x;
    hp_x  = MW'(hp);
    amt_x = MW'(amt);
    return (amt_x >= hp_x) ? '0 : HP_W'(hp_x - amt_x);
  endfunction

  assign w_valid[0]  = bus.unit_dmg_valid;
  assign w_valid[1]  = bus.enemy_dmg_valid;
  assign w_in_sel[0] = bus.unit_dmg_sel;
  assign w_in_sel[1] = bus.enemy_dmg_sel;
  assign w_in_amt[0] = bus.unit_dmg_amt;
  assign w_in_amt[1] = bus.enemy_dmg_amt;

  // Ready is held low during reset; otherwise it reflects only the stored fill level.
  assign bus.unit_dmg_ready  = rst_n & ~w_full[0];
  assign bus.enemy_dmg_ready = rst_n & ~w_full[1];

  always_comb begin
    w_run      = (r_state == ST_RUN) && !bus.restart;
    w_drop_inc = '0;
    for (int s = 0; s < 2; s++) begin
      w_full[s]       = (r_wr_ptr[s][AW] != r_rd_ptr[s][AW]) &&
                        (r_wr_ptr[s][AW-1:0] == r_rd_ptr[s][AW-1:0]);
      w_empty[s]      = (r_wr_ptr[s] == r_rd_ptr[s]);
      w_push[s]       = w_valid[s] && !w_full[s] && !bus.restart;
      w_head_sel[s]   = r_fifo_sel[s][r_rd_ptr[s][AW-1:0]];
      w_head_amt[s]   = r_fifo_amt[s][r_rd_ptr[s][AW-1:0]];
      w_slot[s]       = w_head_sel[s][SLOT_W-1:0];
      w_tower_hit[s]  = (w_head_sel[s] >= SEL_TOWER);
      w_spawn[s]      = w_run && bus.spawn_valid && (int'(bus.spawn_side) == s) &&
                        (int'(bus.spawn_slot) < NUM_SLOTS);
      w_apply[s]      = 1'b0;
      w_drop[s]       = 1'b0;
      w_new_hp[s]     = '0;
      w_tower_next[s] = r_tower[s];
      // A spawn on the slot being hit this edge overrides the damage, which counts as dropped.
      if (!w_empty[s] && w_run) begin
        if (w_tower_hit[s]) begin
          w_apply[s]      = 1'b1;
          w_new_hp[s]     = sat_sub(r_tower[s], w_head_amt[s]);
          w_tower_next[s] = w_new_hp[s];
        end else if (r_alive[s][w_slot[s]] &&
                     !(w_spawn[s] && (bus.spawn_slot == w_slot[s]))) begin
          w_apply[s]  = 1'b1;
          w_new_hp[s] = sat_sub(r_hp[s][w_slot[s]], w_head_amt[s]);
        end else begin
          w_drop[s] = 1'b1;
        end
      end
      w_drop_inc = w_drop_inc + {1'b0, w_drop[s]};
    end
  end

  assign w_drop_sum = {1'b0, r_drop_count} + {7'b0, w_drop_inc};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:  if (!bus.restart && (w_tower_next[0] == '0 || w_tower_next[1] == '0))
                 w_state_next = ST_OVER;
      ST_OVER: if (bus.restart) w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (w_push[s]) begin
        r_fifo_sel[s][r_wr_ptr[s][AW-1:0]] <= w_in_sel[s];
        r_fifo_amt[s][r_wr_ptr[s][AW-1:0]] <= w_in_amt[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        r_wr_ptr[s] <= '0;
        r_rd_ptr[s] <= '0;
        r_alive[s]  <= '0;
        r_tower[s]  <= TOWER_INIT;
        for (int i = 0; i < NUM_SLOTS; i++) r_hp[s][i] <= '0;
      end
      r_won        <= 1'b0;
      r_drop_count <= '0;
    end else if (bus.restart) begin
      for (int s = 0; s < 2; s++) begin
        r_wr_ptr[s] <= '0;
        r_rd_ptr[s] <= '0;
        r_alive[s]  <= '0;
        r_tower[s]  <= TOWER_INIT;
        for (int i = 0; i < NUM_SLOTS; i++) r_hp[s][i] <= '0;
      end
      r_won        <= 1'b0;
      r_drop_count <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (w_push[s])   r_wr_ptr[s] <= r_wr_ptr[s] + PTR_ONE;
        if (!w_empty[s]) r_rd_ptr[s] <= r_rd_ptr[s] + PTR_ONE;
        r_tower[s] <= w_tower_next[s];
        if (w_apply[s] && !w_tower_hit[s]) begin
          r_hp[s][w_slot[s]] <= w_new_hp[s];
          if (w_new_hp[s] == '0) r_alive[s][w_slot[s]] <= 1'b0;
        end
        if (w_spawn[s]) begin
          r_hp[s][bus.spawn_slot]    <= bus.spawn_hp;
          r_alive[s][bus.spawn_slot] <= (bus.spawn_hp != '0);
        end
      end
      r_drop_count <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
      // A simultaneous double tower kill is scored as a friendly loss.
      if (r_state == ST_RUN && w_state_next == ST_OVER)
        r_won <= (w_tower_next[1] == '0) && (w_tower_next[0] != '0);
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_hp
    assign bus.unit_hp[i*HP_W +: HP_W]  = r_hp[0][i];
    assign bus.enemy_hp[i*HP_W +: HP_W] = r_hp[1][i];
  end

  assign bus.unit_alive        = r_alive[0];
  assign bus.enemy_alive       = r_alive[1];
  assign bus.friendly_tower_hp = r_tower[0];
  assign bus.enemy_tower_hp    = r_tower[1];
  assign bus.game_over         = (r_state == ST_OVER);
  assign bus.friendly_won      = r_won;
  assign bus.drop_count        = r_drop_count;
endmodule
